spc_cfg_loader: RTL and testbench

Parametrised serial configuration loader for the VIN SPC front end: receives an LSB-first configuration frame on a one-bit serial line, checks its length (and optionally parity), and commits it atomically to a shadow register on a strobe. It replaces the bare 33-bit shift chain in the SPC core. The shadow register drives the filter, generator and demodulator control fields, and the loader is daisy-chainable through a serial output.

---
 rtl/spc_cfg_loader.sv | 112 +++++++++++
 tb/tb_spc_cfg_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spc_cfg_loader.sv
// Serial LSB-first configuration loader with atomic commit to a shadow register.
// Optional even-parity frame check is enabled by defining SPC_PARITY_EN.
module spc_cfg_loader #(
  parameter int               WIDTH      = 33,
  parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             Cfg_in,
  input  logic             Cfg_en,
  input  logic             Strobe,
  output logic             Cfg_out,
  output logic [WIDTH-1:0] Cfg_word,
  output logic             Cfg_valid,
  output logic             Cfg_err,
  output logic             Busy
);

`ifdef SPC_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int               CNT_W    = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t               state, stateNext;
  logic [FRAME_LEN-1:0] sr, srNext;
  logic [CNT_W-1:0]     cnt, cntNext;
  logic [WIDTH-1:0]     wordNext;
  logic                 validNext, errNext;
  logic                 frameGood;

`ifdef SPC_PARITY_EN
  logic px, pxNext;
  assign frameGood = (cnt == CNT_FULL) && !px;
`else
  assign frameGood = (cnt == CNT_FULL);
`endif

  always_comb begin
    stateNext = state;
    srNext    = sr;
    cntNext   = cnt;
    wordNext  = Cfg_word;
    validNext = Cfg_valid;
    errNext   = Cfg_err;
`ifdef SPC_PARITY_EN
    pxNext    = px;
`endif
    if (Cfg_en) begin
      stateNext = SHIFT;
      srNext    = {Cfg_in, sr[FRAME_LEN-1:1]};
      // Entering SHIFT from IDLE or HOLD always starts a fresh frame.
      if (state != SHIFT) begin
        cntNext = CNT_W'(1);
`ifdef SPC_PARITY_EN
        pxNext  = Cfg_in;
`endif
      end else begin
        if (cnt != CNT_SAT) cntNext = cnt + 1'b1;
`ifdef SPC_PARITY_EN
        pxNext = px ^ Cfg_in;
`endif
      end
      if (Strobe) errNext = 1'b1;
    end else if (Strobe) begin
      stateNext = IDLE;
      cntNext   = '0;
      if (frameGood) begin
        wordNext  = sr[WIDTH-1:0];
        validNext = 1'b1;
        errNext   = 1'b0;
      end else begin
        errNext   = 1'b1;
      end
    end else if (state == SHIFT) begin
      stateNext = HOLD;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      Cfg_word  <= RESET_WORD;
      Cfg_valid <= 1'b0;
      Cfg_err   <= 1'b0;
`ifdef SPC_PARITY_EN
      px        <= 1'b0;
`endif
    end else begin
      state     <= stateNext;
      sr        <= srNext;
      cnt       <= cntNext;
      Cfg_word  <= wordNext;
      Cfg_valid <= validNext;
      Cfg_err   <= errNext;
`ifdef SPC_PARITY_EN
      px        <= pxNext;
`endif
    end
  end

  assign Cfg_out = sr[0];
  assign Busy    = (state != IDLE);

endmodule

// File: tb/tb_spc_cfg_loader.sv
// Bench for spc_cfg_loader: table-driven frames on an 8-bit loader, a 33-bit loader,
// and a two-stage daisy chain; adapts frame length when SPC_PARITY_EN is defined.
module tb_spc_cfg_loader;

`ifdef SPC_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL8  = 8 + int'(PAR);
  localparam int FL33 = 33 + int'(PAR);

  logic Clk = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clk = ~Clk;

  logic aIn = 0, aEn = 0, aStb = 0, aOut, aValid, aErr, aBusy;
  logic [7:0] aWord;
  logic bIn = 0, bEn = 0, bStb = 0, bOut, bValid, bErr, bBusy;
  logic [32:0] bWord;
  logic nIn = 0, nEn = 0, fEn = 0, cStb = 0;
  logic nOut, nValid, nErr, nBusy, fOut, fValid, fErr, fBusy;
  logic [7:0] nWord, fWord;

  spc_cfg_loader #(.WIDTH(8), .RESET_WORD(8'h81)) dutA (
    .Clk(Clk), .Resetn(Resetn), .Cfg_in(aIn), .Cfg_en(aEn), .Strobe(aStb),
    .Cfg_out(aOut), .Cfg_word(aWord), .Cfg_valid(aValid), .Cfg_err(aErr), .Busy(aBusy));

  spc_cfg_loader #(.WIDTH(33)) dut33 (
    .Clk(Clk), .Resetn(Resetn), .Cfg_in(bIn), .Cfg_en(bEn), .Strobe(bStb),
    .Cfg_out(bOut), .Cfg_word(bWord), .Cfg_valid(bValid), .Cfg_err(bErr), .Busy(bBusy));

  spc_cfg_loader #(.WIDTH(8)) dutNear (
    .Clk(Clk), .Resetn(Resetn), .Cfg_in(nIn), .Cfg_en(nEn), .Strobe(cStb),
    .Cfg_out(nOut), .Cfg_word(nWord), .Cfg_valid(nValid), .Cfg_err(nErr), .Busy(nBusy));

  spc_cfg_loader #(.WIDTH(8)) dutFar (
    .Clk(Clk), .Resetn(Resetn), .Cfg_in(nOut), .Cfg_en(fEn), .Strobe(cStb),
    .Cfg_out(fOut), .Cfg_word(fWord), .Cfg_valid(fValid), .Cfg_err(fErr), .Busy(fBusy));

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [63:0] word;
    logic        valid;
    logic        err;
    logic        busy;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string       nm;
    logic [63:0] bits;
    int          len;
    logic [7:0]  expWord;
    logic        expErr;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [63:0] mkFrame(input logic [63:0] data, input int w, input bit flip);
    logic [63:0] r;
    r = data;
    if (PAR) r[w] = (^data) ^ flip;
    return r;
  endfunction

  task automatic pushExp(input string nm, input logic [63:0] w, input logic v, input logic e);
    exp_t x;
    x.nm = nm; x.word = w; x.valid = v; x.err = e; x.busy = 1'b0;
    sbq.push_back(x);
  endtask

  task automatic sbCheck(input logic [63:0] w, input logic v, input logic e, input logic b);
    exp_t x;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'(sbq.size()), 64'd1);
    end else begin
      x = sbq.pop_front();
      chk({x.nm, "_word"}, w, x.word);
      chk({x.nm, "_valid"}, 64'(v), 64'(x.valid));
      chk({x.nm, "_err"}, 64'(e), 64'(x.err));
      chk({x.nm, "_busy"}, 64'(b), 64'(x.busy));
    end
  endtask

  task automatic shiftA(input logic [63:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      aIn = bits[i]; aEn = 1'b1;
      tick();
    end
    aEn = 1'b0; aIn = 1'b0;
  endtask

  task automatic shiftB(input logic [63:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      bIn = bits[i]; bEn = 1'b1;
      tick();
    end
    bEn = 1'b0; bIn = 1'b0;
  endtask

  task automatic strobeA();
    aStb = 1'b1;
    tick();
    aStb = 1'b0;
    sbCheck(64'(aWord), aValid, aErr, aBusy);
  endtask

  task automatic strobeB();
    bStb = 1'b1;
    tick();
    bStb = 1'b0;
    sbCheck(64'(bWord), bValid, bErr, bBusy);
  endtask

  initial begin
    logic [63:0] f, fFar, fNear, stream;
    logic [7:0]  nearData;

    vecs[0] = '{"goodA5",  mkFrame(64'hA5, 8, 0), FL8,     8'hA5, 1'b0};
    vecs[1] = '{"short",   mkFrame(64'h5F, 8, 0), FL8 - 1, 8'hA5, 1'b1};
    vecs[2] = '{"long",    mkFrame(64'h5F, 8, 0), FL8 + 1, 8'hA5, 1'b1};
    vecs[3] = '{"good3C",  mkFrame(64'h3C, 8, 0), FL8,     8'h3C, 1'b0};
    vecs[4] = '{"idleStb", 64'h0,                 0,       8'h3C, 1'b1};
    vecs[5] = '{"parBad",  mkFrame(64'hA5, 8, 1), FL8,     (PAR ? 8'h3C : 8'hA5), PAR};
    vecs[6] = '{"goodFF",  mkFrame(64'hFF, 8, 0), FL8,     8'hFF, 1'b0};

    // Reset state
    tick(); tick();
    chk("rst_word", 64'(aWord), 64'h81);
    chk("rst_flags", {61'd0, aValid, aErr, aBusy}, 64'd0);
    chk("rst_out", 64'(aOut), 64'd0);
    chk("rst_word33", 64'(bWord), 64'd0);
    Resetn = 1'b1;
    tick();

    // Table-driven frames on the 8-bit loader
    for (int v = 0; v < 7; v++) begin
      shiftA(vecs[v].bits, vecs[v].len);
      if (vecs[v].len > 0) chk({vecs[v].nm, "_busyHold"}, 64'(aBusy), 64'd1);
      if (vecs[v].len >= FL8)
        chk({vecs[v].nm, "_out"}, 64'(aOut), 64'(vecs[v].bits[vecs[v].len - FL8]));
      pushExp(vecs[v].nm, 64'(vecs[v].expWord), 1'b1, vecs[v].expErr);
      strobeA();
    end

    // Strobe while shifting: no commit, error, frame continues
    f = mkFrame(64'h5C, 8, 0);
    shiftA(f, 4);
    aIn = f[4]; aEn = 1'b1; aStb = 1'b1;
    tick();
    aStb = 1'b0;
    chk("stbEn_err", 64'(aErr), 64'd1);
    chk("stbEn_word", 64'(aWord), 64'hFF);
    chk("stbEn_busy", 64'(aBusy), 64'd1);
    shiftA(f >> 5, FL8 - 5);
    pushExp("stbEnDone", 64'h5C, 1'b1, 1'b0);
    strobeA();

    // Strobe-less HOLD followed by a new frame discards the old bits
    shiftA(mkFrame(64'h11, 8, 0), 5);
    tick();
    chk("hold_busy", 64'(aBusy), 64'd1);
    shiftA(mkFrame(64'h96, 8, 0), FL8);
    pushExp("afterHold", 64'h96, 1'b1, 1'b0);
    strobeA();

    // 33-bit loader: commit, reset mid-frame, recommit
    shiftB(mkFrame(64'h1_7AB6_E065, 33, 0), FL33);
    pushExp("w33a", 64'h1_7AB6_E065, 1'b1, 1'b0);
    strobeB();
    shiftB(mkFrame(64'h0_0F0F_1234, 33, 0), 10);
    #3 Resetn = 1'b0;
    #1;
    chk("rst33_word", 64'(bWord), 64'd0);
    chk("rst33_valid", 64'(bValid), 64'd0);
    chk("rst33_busy", 64'(bBusy), 64'd0);
    chk("rst33_cnt", 64'(dut33.cnt), 64'd0);
    chk("rst33_wordA", 64'(aWord), 64'h81);
    #1 Resetn = 1'b1;
    tick();
    shiftB(mkFrame(64'h0_1234_5678, 33, 0), FL33);
    pushExp("w33b", 64'h0_1234_5678, 1'b1, 1'b0);
    strobeB();

    // Daisy chain: far frame first on the wire, far enabled only for its own bits
    fFar   = mkFrame(64'hC3, 8, 0);
    fNear  = mkFrame(64'h5A, 8, 0);
    stream = fFar | (fNear << FL8);
    for (int i = 0; i < 2 * FL8; i++) begin
      nIn = stream[i]; nEn = 1'b1; fEn = (i >= FL8);
      tick();
    end
    nEn = 1'b0; fEn = 1'b0; nIn = 1'b0;
    pushExp("far", 64'hC3, 1'b1, 1'b0);
    cStb = 1'b1;
    tick();
    cStb = 1'b0;
    sbCheck(64'(fWord), fValid, fErr, fBusy);
    chk("near_err", 64'(nErr), 64'd1);
    chk("near_word", 64'(nWord), 64'd0);
    chk("near_valid", 64'(nValid), 64'd0);
    nearData = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      chk("near_sr", 64'(nOut), 64'(nearData[i]));
      nEn = 1'b1;
      tick();
    end
    nEn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
